// File: rtl/count_seq_checker_pkg.sv
// Shared types and default parameters for the counter sequence checker.
package count_seq_checker_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACQUIRE = 2'd1,
        LOCKED  = 2'd2
    } state_e;

    localparam int DEF_WIDTH     = 4;
    localparam int DEF_ERR_CNT_W = 8;
    localparam int DEF_LOCK_N    = 3;
    localparam int DEF_STALL_MAX = 4;

    // Streak covers LOCK_N up to 15; idle counter covers STALL_MAX up to 255.
    localparam int STREAK_W = 4;
    localparam int IDLE_W   = 8;

endpackage

// File: rtl/count_seq_sat_cnt.sv
// Saturating up-counter with synchronous clear; clear takes priority over increment.
module count_seq_sat_cnt #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc_i,
    input  logic         clr_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != {W{1'b1}})) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/count_seq_checker.sv
// Checks that each qualified count sample is the previous one plus one (mod 2^WIDTH).
// Optional mismatch capture outputs are enabled by COUNT_SEQ_CHECKER_CAPTURE_EN.
module count_seq_checker
    import count_seq_checker_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int ERR_CNT_W = DEF_ERR_CNT_W,
    parameter int LOCK_N    = DEF_LOCK_N,
    parameter int STALL_MAX = DEF_STALL_MAX
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WIDTH-1:0]     count_in,
    input  logic                 count_vld,
    input  logic                 clear,
    output logic                 locked,
    output logic                 mismatch,
    output logic                 wrap,
    output logic                 stall,
    output logic [ERR_CNT_W-1:0] err_cnt,
    output logic [WIDTH-1:0]     expected,
`ifdef COUNT_SEQ_CHECKER_CAPTURE_EN
    output logic [WIDTH-1:0]     bad_value,
    output logic [WIDTH-1:0]     bad_expected,
`endif
    output state_e               state_dbg
);

    state_e              state_q, state_d;
    logic [STREAK_W-1:0] streak_q, streak_d;
    logic [WIDTH-1:0]    expected_q, expected_d;
    logic [IDLE_W-1:0]   idle_q, idle_d;
    logic                mismatch_q, mismatch_d;
    logic                wrap_q, wrap_d;
    logic                stall_q, stall_d;
    logic                sample_ok;

    assign sample_ok = count_vld && (count_in == expected_q);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            streak_q   <= '0;
            expected_q <= '0;
        end else begin
            state_q    <= state_d;
            streak_q   <= streak_d;
            expected_q <= expected_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        streak_d   = streak_q;
        expected_d = expected_q;
        mismatch_d = 1'b0;
        wrap_d     = 1'b0;
        // Every qualified sample re-anchors the expectation, right or wrong.
        if (count_vld) begin
            expected_d = count_in + WIDTH'(1);
        end
        case (state_q)
            IDLE: begin
                if (count_vld) begin
                    streak_d = '0;
                    state_d  = ACQUIRE;
                end
            end
            ACQUIRE: begin
                if (sample_ok) begin
                    streak_d = streak_q + STREAK_W'(1);
                    if ((streak_q + STREAK_W'(1)) == STREAK_W'(LOCK_N)) begin
                        state_d = LOCKED;
                    end
                end else if (count_vld) begin
                    streak_d = '0;
                end
            end
            LOCKED: begin
                if (sample_ok) begin
                    wrap_d = (count_in == '0);
                end else if (count_vld) begin
                    mismatch_d = 1'b1;
                    streak_d   = '0;
                    state_d    = ACQUIRE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Idle-cycle tracking only runs while locked and without a sample or clear.
    always_comb begin
        idle_d  = idle_q;
        stall_d = stall_q;
        if ((state_q != LOCKED) || count_vld || clear) begin
            idle_d  = '0;
            stall_d = 1'b0;
        end else begin
            if (idle_q != IDLE_W'(STALL_MAX)) begin
                idle_d = idle_q + IDLE_W'(1);
            end
            if (idle_d == IDLE_W'(STALL_MAX)) begin
                stall_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idle_q     <= '0;
            stall_q    <= 1'b0;
            mismatch_q <= 1'b0;
            wrap_q     <= 1'b0;
        end else begin
            idle_q     <= idle_d;
            stall_q    <= stall_d;
            mismatch_q <= mismatch_d;
            wrap_q     <= wrap_d;
        end
    end

    count_seq_sat_cnt #(
        .W(ERR_CNT_W)
    ) u_err_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc_i (mismatch_d),
        .clr_i (clear),
        .cnt_o (err_cnt)
    );

`ifdef COUNT_SEQ_CHECKER_CAPTURE_EN
    logic [WIDTH-1:0] bad_value_q;
    logic [WIDTH-1:0] bad_expected_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bad_value_q    <= '0;
            bad_expected_q <= '0;
        end else if (clear) begin
            bad_value_q    <= '0;
            bad_expected_q <= '0;
        end else if (mismatch_d) begin
            bad_value_q    <= count_in;
            bad_expected_q <= expected_q;
        end
    end

    assign bad_value    = bad_value_q;
    assign bad_expected = bad_expected_q;
`endif

    always_comb begin
        locked    = (state_q == LOCKED);
        mismatch  = mismatch_q;
        wrap      = wrap_q;
        stall     = stall_q;
        expected  = expected_q;
        state_dbg = state_q;
    end

endmodule

// File: tb/tb_count_seq_checker.sv
// Directed bench for count_seq_checker: vector table plus multi-cycle corner sequences.
module tb_count_seq_checker;
    import count_seq_checker_pkg::*;

    logic       clk;
    logic       rst;
    logic [3:0] count_in;
    logic       count_vld;
    logic       clear;
    logic       locked;
    logic       mismatch;
    logic       wrap;
    logic       stall;
    logic [7:0] err_cnt;
    logic [3:0] expected;
`ifdef COUNT_SEQ_CHECKER_CAPTURE_EN
    logic [3:0] bad_value;
    logic [3:0] bad_expected;
`endif
    state_e     state_dbg;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        logic       vld;
        logic [3:0] cin;
        logic       clr;
        logic       lck;
        logic       mm;
        logic       wr;
        logic       st;
        logic [7:0] err;
        logic [3:0] ex;
    } vec_t;

    vec_t vq[$];

    count_seq_checker #(
        .WIDTH(4), .ERR_CNT_W(8), .LOCK_N(3), .STALL_MAX(4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .count_in     (count_in),
        .count_vld    (count_vld),
        .clear        (clear),
        .locked       (locked),
        .mismatch     (mismatch),
        .wrap         (wrap),
        .stall        (stall),
        .err_cnt      (err_cnt),
        .expected     (expected),
`ifdef COUNT_SEQ_CHECKER_CAPTURE_EN
        .bad_value    (bad_value),
        .bad_expected (bad_expected),
`endif
        .state_dbg    (state_dbg)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exv);
        n_chk++;
        if (act !== exv) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exv);
        end
    endtask

    task automatic add(input int vld, input int cin, input int clr, input int lck,
                       input int mm, input int wr, input int st, input int err, input int ex);
        vec_t v;
        v.vld = vld[0];
        v.cin = cin[3:0];
        v.clr = clr[0];
        v.lck = lck[0];
        v.mm  = mm[0];
        v.wr  = wr[0];
        v.st  = st[0];
        v.err = err[7:0];
        v.ex  = ex[3:0];
        vq.push_back(v);
    endtask

    // Drive at a negedge, let one rising edge sample it, return at the next negedge.
    task automatic send(input int vld, input int cin, input int clr);
        count_vld = vld[0];
        count_in  = cin[3:0];
        clear     = clr[0];
        @(posedge clk);
        @(negedge clk);
        count_vld = 1'b0;
        clear     = 1'b0;
    endtask

    task automatic chk_all(input string tag, input vec_t v);
        chk({tag, ".locked"},   32'(locked),   32'(v.lck));
        chk({tag, ".mismatch"}, 32'(mismatch), 32'(v.mm));
        chk({tag, ".wrap"},     32'(wrap),     32'(v.wr));
        chk({tag, ".stall"},    32'(stall),    32'(v.st));
        chk({tag, ".err_cnt"},  32'(err_cnt),  32'(v.err));
        chk({tag, ".expected"}, 32'(expected), 32'(v.ex));
    endtask

    initial begin
        vec_t zero_v;
        logic [3:0] e;
        logic [3:0] w;
        int err_model;

        rst = 1'b0;
        count_in = '0;
        count_vld = 1'b0;
        clear = 1'b0;
        zero_v = '{default: '0};

        repeat (2) @(negedge clk);
        chk_all("reset", zero_v);
        rst = 1'b1;
        @(negedge clk);

        // Acquire and lock on 5,6,7,8
        add(1, 5, 0, 0, 0, 0, 0, 0, 6);
        add(1, 6, 0, 0, 0, 0, 0, 0, 7);
        add(1, 7, 0, 0, 0, 0, 0, 0, 8);
        add(1, 8, 0, 1, 0, 0, 0, 0, 9);
        for (int c = 9; c <= 13; c++) add(1, c, 0, 1, 0, 0, 0, 0, c + 1);
        // Wrap through 14,15,0
        add(1, 14, 0, 1, 0, 0, 0, 0, 15);
        add(1, 15, 0, 1, 0, 0, 0, 0, 0);
        add(1, 0,  0, 1, 0, 1, 0, 0, 1);
        add(1, 1,  0, 1, 0, 0, 0, 0, 2);
        add(1, 2,  0, 1, 0, 0, 0, 0, 3);
        // Mismatch with expected=3, then relock on 8,9,10
        add(1, 7,  0, 0, 1, 0, 0, 1, 8);
        add(1, 8,  0, 0, 0, 0, 0, 1, 9);
        add(1, 9,  0, 0, 0, 0, 0, 1, 10);
        add(1, 10, 0, 1, 0, 0, 0, 1, 11);
        // Stall after 4 idle cycles, held, cleared by a sample
        add(0, 0,  0, 1, 0, 0, 0, 1, 11);
        add(0, 0,  0, 1, 0, 0, 0, 1, 11);
        add(0, 0,  0, 1, 0, 0, 0, 1, 11);
        add(0, 0,  0, 1, 0, 0, 1, 1, 11);
        add(0, 0,  0, 1, 0, 0, 1, 1, 11);
        add(1, 11, 0, 1, 0, 0, 0, 1, 12);
        // Clear on the stall threshold cycle suppresses stall and restarts idle count
        add(0, 0,  0, 1, 0, 0, 0, 1, 12);
        add(0, 0,  0, 1, 0, 0, 0, 1, 12);
        add(0, 0,  0, 1, 0, 0, 0, 1, 12);
        add(0, 0,  1, 1, 0, 0, 0, 0, 12);
        add(0, 0,  0, 1, 0, 0, 0, 0, 12);
        add(1, 12, 0, 1, 0, 0, 0, 0, 13);
        // Mismatch, relock, then clear coincident with mismatch
        add(1, 5,  0, 0, 1, 0, 0, 1, 6);
        add(1, 6,  0, 0, 0, 0, 0, 1, 7);
        add(1, 7,  0, 0, 0, 0, 0, 1, 8);
        add(1, 8,  0, 1, 0, 0, 0, 1, 9);
        add(1, 3,  1, 0, 1, 0, 0, 0, 4);
        // Resync in ACQUIRE, lock completes on a 15->0 step without a wrap pulse
        add(1, 13, 0, 0, 0, 0, 0, 0, 14);
        add(1, 14, 0, 0, 0, 0, 0, 0, 15);
        add(1, 15, 0, 0, 0, 0, 0, 0, 0);
        add(1, 0,  0, 1, 0, 0, 0, 0, 1);

        foreach (vq[i]) begin
            send(int'(vq[i].vld), int'(vq[i].cin), int'(vq[i].clr));
            chk_all($sformatf("vec%0d", i), vq[i]);
        end

        // Saturation: 300 mismatches, each followed by a 3-sample relock
        e = 4'd1;
        err_model = 0;
        for (int i = 0; i < 300; i++) begin
            w = e + 4'd5;
            send(1, int'(w), 0);
            err_model = (err_model < 255) ? err_model + 1 : 255;
            chk($sformatf("sat%0d.mismatch", i), 32'(mismatch), 32'd1);
            chk($sformatf("sat%0d.err_cnt", i), 32'(err_cnt), 32'(err_model));
            send(1, int'(w + 4'd1), 0);
            send(1, int'(w + 4'd2), 0);
            send(1, int'(w + 4'd3), 0);
            e = w + 4'd4;
        end
        chk("sat.locked", 32'(locked), 32'd1);
        chk("sat.final", 32'(err_cnt), 32'd255);

        // Clear with mismatch from saturation
        w = e + 4'd7;
        send(1, int'(w), 1);
        chk("satclr.mismatch", 32'(mismatch), 32'd1);
        chk("satclr.err_cnt", 32'(err_cnt), 32'd0);
        e = w + 4'd1;

        // Build err_cnt=2 while locked
        for (int k = 0; k < 3; k++) begin
            send(1, int'(e), 0);
            send(1, int'(e + 4'd1), 0);
            send(1, int'(e + 4'd2), 0);
            e = e + 4'd3;
            if (k < 2) begin
                w = e + 4'd9;
                send(1, int'(w), 0);
                e = w + 4'd1;
            end
        end
        chk("pre_rst.locked", 32'(locked), 32'd1);
        chk("pre_rst.err_cnt", 32'(err_cnt), 32'd2);

        // Asynchronous reset between clock edges
        #2 rst = 1'b0;
        #1 chk_all("async_rst", zero_v);
        @(negedge clk);
        rst = 1'b1;

        // Relock needs a first sample plus 3 correct increments
        send(1, 0, 0);
        send(1, 1, 0);
        send(1, 2, 0);
        chk("relock.not_yet", 32'(locked), 32'd0);
        send(1, 3, 0);
        chk("relock.locked", 32'(locked), 32'd1);
        chk("relock.expected", 32'(expected), 32'd4);
        send(1, 9, 0);
        chk("cap.mismatch", 32'(mismatch), 32'd1);
        chk("cap.err_cnt", 32'(err_cnt), 32'd1);
`ifdef COUNT_SEQ_CHECKER_CAPTURE_EN
        chk("cap.bad_value", 32'(bad_value), 32'd9);
        chk("cap.bad_expected", 32'(bad_expected), 32'd4);
        send(0, 0, 1);
        chk("cap_clr.bad_value", 32'(bad_value), 32'd0);
        chk("cap_clr.bad_expected", 32'(bad_expected), 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/count_seq_checker.md
Name: count_seq_checker

Overview:
- Sequence checker that sits on the output of the free-running up-counter and verifies its count bus.
- Each qualified sample must equal the previous sample plus one, modulo 2^WIDTH.
- Reports lock status, mismatch and wrap pulses, stalls, and a saturating error count.
- Used as an in-design monitor and as the scoreboard front end in counter benches.

Parameters:
- WIDTH, 4, width of the observed count bus.
- ERR_CNT_W, 8, width of the saturating error counter.
- LOCK_N, 3, consecutive correct increments required to declare lock (range 1..15).
- STALL_MAX, 4, consecutive cycles without count_vld while locked before stall asserts (range 1..255).

Ports:
- clk  in  1  single clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- count_in  in  WIDTH  observed count value.
- count_vld  in  1  count_in is sampled on cycles where this is 1.
- clear  in  1  synchronous clear of err_cnt and stall; does not affect FSM state.
- locked  out  1  level; 1 while the FSM is in LOCKED.
- mismatch  out  1  one-cycle pulse on a wrong sample while locked.
- wrap  out  1  one-cycle pulse on a correct all-ones-to-zero transition while locked.
- stall  out  1  level; stall condition present.
- err_cnt  out  ERR_CNT_W  saturating mismatch count.
- expected  out  WIDTH  next value the checker expects.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; locked, mismatch, wrap and stall = 0; err_cnt=0; expected=0; streak=0; idle-cycle counter=0.
- All outputs are registered. A sample on cycle N is reflected on the outputs in cycle N+1.
- Cycles with count_vld=0 leave expected and streak unchanged. They only advance the idle-cycle counter.
- Arithmetic: expected <= count_in + 1, truncated to WIDTH bits (wraps naturally).

FSM:
- IDLE: on count_vld, expected <= count_in+1, streak <= 0, go to ACQUIRE.
- ACQUIRE:
  - Correct sample: streak++. If streak reaches LOCK_N, go to LOCKED.
  - Wrong sample: streak <= 0, expected <= count_in+1 (resync). No error counted, no mismatch pulse.
- LOCKED:
  - Correct sample: expected <= count_in+1.
  - Correct sample with count_in==0: also pulse wrap.
  - Wrong sample: pulse mismatch, err_cnt++, expected <= count_in+1, streak <= 0, go to ACQUIRE. locked drops in the following cycle.

Stall:
- Only in LOCKED: the idle-cycle counter increments on each cycle with count_vld=0 and clears on count_vld=1.
- stall sets when the idle-cycle count reaches STALL_MAX.
- stall clears on the next count_vld=1, on clear, or on leaving LOCKED.
- Samples during stall are still checked normally.

err_cnt:
- Saturates at 2^ERR_CNT_W-1 and never wraps.

Simultaneous events:
- clear together with a mismatch: clear wins, so err_cnt=0. The mismatch pulse and state change still occur.
- clear together with the stall threshold: stall stays 0 and the idle-cycle counter clears.
- A correct wrap sample that completes the lock streak in ACQUIRE: go to LOCKED, no wrap pulse (wrap requires already being in LOCKED).
- Reset mid-operation: immediate return to reset values. Lock must be re-acquired.

Optional Feature:
- Macro: COUNT_SEQ_CHECKER_CAPTURE_EN.
- Defined:
  - Adds outputs bad_value (WIDTH) and bad_expected (WIDTH), both reset to 0.
  - On each mismatch, both load count_in and the pre-update expected.
  - Both hold until the next mismatch or clear; clear zeroes them.
- Undefined: the ports and registers are absent; all other behaviour is identical.

Decomposition:
- Package count_seq_checker_pkg holds:
  - the state typedef (IDLE=2'd0, ACQUIRE=2'd1, LOCKED=2'd2);
  - defaults for WIDTH, ERR_CNT_W, LOCK_N and STALL_MAX.
- One sub-module, count_seq_sat_cnt: a parameterised saturating counter with inc and clr inputs (clr priority). It implements err_cnt.

Test Plan:
- Reset at 0, then count_vld=1 with count_in 5,6,7,8 on consecutive cycles → locked=1 in the cycle after count_in=8 is sampled. err_cnt=0, expected=9.
- Locked, then drive 14,15,0 → wrap pulses exactly one cycle, in the cycle after 0 is sampled. mismatch stays 0, expected=1.
- Locked with expected=3, drive 7 → mismatch pulse, err_cnt=1, locked=0 the next cycle, expected=8. Then 8,9,10 → locked=1 again.
- Locked, hold count_vld=0 for 4 cycles → stall=1 on the cycle after the 4th idle cycle. A count_vld=1 sample → stall=0 the next cycle.
- Force 300 mismatches with ERR_CNT_W=8 → err_cnt sticks at 255. Assert clear on the same cycle as a mismatch → err_cnt=0 and mismatch still pulses.
- Assert rst=0 asynchronously while locked with err_cnt=2 → all outputs 0 immediately, without waiting for a clock edge. After release, 3 correct increments are needed to relock. With COUNT_SEQ_CHECKER_CAPTURE_EN, expected=4 and count_in=9 → bad_value=9, bad_expected=4.
